// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC scheduler: FSM encoding, default sizing
// and the scaler sign polarity.
package cordic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCALE   = 3'd1,
        ST_INIT    = 3'd2,
        ST_ITER    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam int DEF_ITERATIONS = 16;
    localparam int DEF_IDX_WIDTH  = 5;

    // scl_sign value meaning "keep the core result as is"
    localparam logic SIGN_POS = 1'b1;

    // last-served pointer after reset: req1, so req0 wins the first tie
    localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/cordic_scheduler_if.sv
// Request and result handshakes of the CORDIC scheduler. The slave side is
// the scheduler; the master side is the requesters plus the result consumer.
interface cordic_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_angle;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_angle;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_cos;
    logic [DATA_WIDTH-1:0] out_sin;
    logic                  out_tag;

    modport master (
        output req0_valid, req0_angle, req1_valid, req1_angle, out_ready,
        input  req0_ready, req1_ready, out_valid, out_cos, out_sin, out_tag
    );

    modport slave (
        input  req0_valid, req0_angle, req1_valid, req1_angle, out_ready,
        output req0_ready, req1_ready, out_valid, out_cos, out_sin, out_tag
    );

endinterface

// File: rtl/cordic_rr_arb.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not served last wins.
module cordic_rr_arb
    import cordic_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    input  logic en,
    output logic grant,
    output logic gnt_valid
);

    // grant selection and qualification
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1)
            grant = ~last;
        else if (valid1)
            grant = 1'b1;
        gnt_valid = en & (valid0 | valid1);
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Scheduler/sequencer for the shared CORDIC datapath: arbitrates two angle
// requesters, strobes the scaler, steps the iterative core ITERATIONS times
// and returns sign-corrected cos/sin with the requester tag.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITERATIONS = DEF_ITERATIONS,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    cordic_scheduler_if.slave     bus,
    output logic [DATA_WIDTH-1:0] scl_angle,
    output logic                  scl_load,
    input  logic                  scl_sign,
    output logic                  core_init,
    output logic                  core_step,
    output logic [IDX_WIDTH-1:0]  core_idx,
    input  logic [DATA_WIDTH-1:0] core_x,
    input  logic [DATA_WIDTH-1:0] core_y
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(ITERATIONS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  sign_q;
    logic                  tag_q;
    logic                  last;
    logic [DATA_WIDTH-1:0] cos_q;
    logic [DATA_WIDTH-1:0] sin_q;
    logic                  otag_q;
    logic                  grant;
    logic                  gnt_valid;
    logic                  arb_en;
    logic                  ready0;
    logic                  ready1;

    // Arbitration only counts while idle, enabled and out of reset, so a
    // grant is always a real handshake.
    assign arb_en = (state == ST_IDLE) & clk_en & ~rst;

    cordic_rr_arb u_arb (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .last      (last),
        .en        (arb_en),
        .grant     (grant),
        .gnt_valid (gnt_valid)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // next state and strobes; nothing moves or fires while clk_en is low
    always_comb begin
        state_nxt = state;
        scl_load  = 1'b0;
        core_init = 1'b0;
        core_step = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        if (clk_en && !rst) begin
            case (state)
                ST_IDLE: begin
                    ready0 = gnt_valid & ~grant;
                    ready1 = gnt_valid & grant;
                    if (gnt_valid)
                        state_nxt = ST_SCALE;
                end
                ST_SCALE: begin
                    scl_load  = 1'b1;
                    state_nxt = ST_INIT;
                end
                ST_INIT: begin
                    core_init = 1'b1;
                    state_nxt = ST_ITER;
                end
                ST_ITER: begin
                    core_step = 1'b1;
                    if (idx == IDX_LAST)
                        state_nxt = ST_CAPTURE;
                end
                ST_CAPTURE: state_nxt = ST_HOLD;
                ST_HOLD: begin
                    if (bus.out_ready)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Request capture, iteration counter, result registers and the
    // last-served pointer. The counter returns to 0 after the final step so
    // core_idx reads 0 outside ITER.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_angle <= '0;
            idx       <= '0;
            sign_q    <= SIGN_POS;
            tag_q     <= 1'b0;
            last      <= LAST_RESET;
            cos_q     <= '0;
            sin_q     <= '0;
            otag_q    <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        scl_angle <= grant ? bus.req1_angle : bus.req0_angle;
                        tag_q     <= grant;
                    end
                end
                ST_INIT: begin
                    sign_q <= scl_sign;
                    idx    <= '0;
                end
                ST_ITER: idx <= (idx == IDX_LAST) ? '0 : idx + IDX_WIDTH'(1);
                ST_CAPTURE: begin
                    cos_q  <= (sign_q == SIGN_POS) ? core_x : -core_x;
                    sin_q  <= (sign_q == SIGN_POS) ? core_y : -core_y;
                    otag_q <= tag_q;
                end
                ST_HOLD: begin
                    if (bus.out_ready)
                        last <= otag_q;
                end
                default: ;
            endcase
        end
    end

    assign core_idx       = idx;
    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = (state == ST_HOLD);
    assign bus.out_cos    = cos_q;
    assign bus.out_sin    = sin_q;
    assign bus.out_tag    = otag_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler: stimulus pushes expected results at
// accept time; a negedge monitor checks grants, strobe timeline, latency and
// results against a timeline/arithmetic reference model.
module tb_cordic_scheduler;

    localparam int DW  = 32;
    localparam int IT  = 16;
    localparam int IW  = 5;
    localparam int LAT = IT + 4;

    typedef struct {
        logic          tag;
        logic [DW-1:0] c;
        logic [DW-1:0] s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic [DW-1:0] scl_angle;
    logic          scl_load;
    logic          scl_sign;
    logic          core_init;
    logic          core_step;
    logic [IW-1:0] core_idx;
    logic [DW-1:0] core_x;
    logic [DW-1:0] core_y;

    // directed core values, or a core model derived from the scaled angle
    bit            rand_core = 1'b0;
    logic [DW-1:0] dir_x = '0;
    logic [DW-1:0] dir_y = '0;
    logic          dir_s = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic acc_log[$];
    bit   inflight = 1'b0;
    bit   seen_valid = 1'b0;
    int   acc_cyc = 0;
    int   stalls = 0;
    int   out_hs_cyc = 0;
    int   last_lat = 0;
    logic m_last = 1'b1;
    logic [DW-1:0] acc_angle = '0;
    logic [DW-1:0] last_cos = '0;
    logic [DW-1:0] last_sin = '0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    cordic_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    cordic_scheduler #(.DATA_WIDTH(DW), .ITERATIONS(IT), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .bus       (bus),
        .scl_angle (scl_angle),
        .scl_load  (scl_load),
        .scl_sign  (scl_sign),
        .core_init (core_init),
        .core_step (core_step),
        .core_idx  (core_idx),
        .core_x    (core_x),
        .core_y    (core_y)
    );

    function automatic logic [DW-1:0] model_x(input bit rc, input logic [DW-1:0] a, input logic [DW-1:0] d);
        return rc ? a * 32'd3 + 32'd1 : d;
    endfunction
    function automatic logic [DW-1:0] model_y(input bit rc, input logic [DW-1:0] a, input logic [DW-1:0] d);
        return rc ? ~a ^ 32'h5A5A_0F0F : d;
    endfunction
    function automatic logic model_s(input bit rc, input logic [DW-1:0] a, input logic d);
        return rc ? a[7] : d;
    endfunction
    function automatic logic [DW-1:0] apply_sign(input logic s, input logic [DW-1:0] v);
        return s ? v : 32'd0 - v;
    endfunction

    assign core_x   = model_x(rand_core, scl_angle, dir_x);
    assign core_y   = model_y(rand_core, scl_angle, dir_y);
    assign scl_sign = model_s(rand_core, scl_angle, dir_s);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor / scoreboard
    always @(negedge clk) begin : mon
        logic [1:0]    act_rdy;
        logic [1:0]    exp_rdy;
        logic [IW+2:0] act_stb;
        logic [IW+2:0] exp_stb;
        logic          g;
        int            eoff;
        act_rdy = {bus.req1_ready, bus.req0_ready};
        if (rst) begin
            chk("ready_in_reset", 64'(act_rdy), 64'd0);
            sb.delete();
            inflight   = 1'b0;
            seen_valid = 1'b0;
            m_last     = 1'b1;
        end else begin
            exp_rdy = 2'b00;
            if (!inflight && clk_en && (bus.req0_valid || bus.req1_valid)) begin
                g = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
                exp_rdy = g ? 2'b10 : 2'b01;
            end
            chk("ready", 64'(act_rdy), 64'(exp_rdy));

            exp_stb = '0;
            eoff = 0;
            if (inflight && clk_en) begin
                eoff = cyc - acc_cyc - stalls;
                if (eoff == 1) exp_stb[IW+2] = 1'b1;
                if (eoff == 2) exp_stb[IW+1] = 1'b1;
                if (eoff >= 3 && eoff < 3 + IT) begin
                    exp_stb[IW]     = 1'b1;
                    exp_stb[IW-1:0] = IW'(eoff - 3);
                end
            end
            act_stb = {scl_load, core_init, core_step, core_step ? core_idx : {IW{1'b0}}};
            chk("strobes", 64'(act_stb), 64'(exp_stb));
            if (inflight && clk_en && eoff == 1)
                chk("scl_angle", 64'(scl_angle), 64'(acc_angle));

            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: out_valid with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    if (!seen_valid) begin
                        last_lat = cyc - acc_cyc;
                        chk("latency", 64'(last_lat), 64'(LAT + stalls));
                        seen_valid = 1'b1;
                    end
                    chk("out_cos", 64'(bus.out_cos), 64'(sb[0].c));
                    chk("out_sin", 64'(bus.out_sin), 64'(sb[0].s));
                    chk("out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
                    if (clk_en && bus.out_ready) begin
                        m_last     = sb[0].tag;
                        last_cos   = bus.out_cos;
                        last_sin   = bus.out_sin;
                        void'(sb.pop_front());
                        inflight   = 1'b0;
                        seen_valid = 1'b0;
                        out_hs_cyc = cyc;
                    end
                end
            end
            if (inflight && !seen_valid && !clk_en)
                stalls++;

            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                g = bus.req1_ready;
                acc_angle = g ? bus.req1_angle : bus.req0_angle;
                sb.push_back('{tag: g,
                    c: apply_sign(model_s(rand_core, acc_angle, dir_s), model_x(rand_core, acc_angle, dir_x)),
                    s: apply_sign(model_s(rand_core, acc_angle, dir_s), model_y(rand_core, acc_angle, dir_y))});
                acc_log.push_back(g);
                inflight   = 1'b1;
                seen_valid = 1'b0;
                acc_cyc    = cyc;
                stalls     = 0;
            end
        end
    end

    // present one request and hold it until accepted
    task automatic issue(input bit i, input logic [DW-1:0] a, input bit drop);
        int n = 0;
        if (i) begin bus.req1_valid = 1'b1; bus.req1_angle = a; end
        else   begin bus.req0_valid = 1'b1; bus.req0_angle = a; end
        do begin
            @(negedge clk);
            n++;
        end while (!(i ? bus.req1_ready : bus.req0_ready) && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL req%0d_timeout: not accepted within %0d cycles", i, n);
        end
        @(posedge clk); #1;
        if (drop) begin
            if (i) bus.req1_valid = 1'b0;
            else   bus.req0_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((inflight || sb.size() != 0) && n < 1000);
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: transaction still pending after %0d cycles", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_step(input int k);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(core_step && core_idx == IW'(k)) && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: idx %0d never stepped", k);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_scl_angle", 64'(scl_angle), 64'd0);
        chk("rst_strobes", 64'({scl_load, core_init, core_step}), 64'd0);
        chk("rst_core_idx", 64'(core_idx), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_cos", 64'(bus.out_cos), 64'd0);
        chk("rst_out_sin", 64'(bus.out_sin), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clk_en = 1'b1;
        bus.out_ready  = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_angle = '0;
        bus.req1_angle = '0;
        do_reset();
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;

        // single req0, positive sign
        dir_x = 32'h0B50_0000; dir_y = 32'h0B50_0000; dir_s = 1'b1;
        issue(1'b0, 32'h2000_0000, 1'b1);
        wait_idle();
        chk("t1_cos", 64'(last_cos), 64'h0B50_0000);
        chk("t1_lat", 64'(last_lat), 64'd20);

        // negate path, including the most-negative wrap
        dir_x = 32'h0000_0001; dir_y = 32'h8000_0000; dir_s = 1'b0;
        issue(1'b1, 32'h1234_5678, 1'b1);
        wait_idle();
        chk("neg_cos", 64'(last_cos), 64'hFFFF_FFFF);
        chk("neg_sin", 64'(last_sin), 64'h8000_0000);

        // clk_en low for 3 cycles right after idx 5 was stepped
        dir_x = 32'h0102_0304; dir_y = 32'hF0E0_D0C0; dir_s = 1'b1;
        fork
            issue(1'b0, 32'h0FED_CBA9, 1'b1);
            begin
                wait_step(5);
                @(posedge clk); #1 clk_en = 1'b0;
                repeat (3) @(posedge clk);
                #1 clk_en = 1'b1;
            end
        join
        wait_idle();
        chk("stall_lat", 64'(last_lat), 64'd23);

        // consumer back-pressure for 10 cycles with req1 waiting
        bus.out_ready = 1'b0;
        fork
            issue(1'b0, 32'h7777_0001, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 issue(1'b1, 32'h7777_0002, 1'b1);
            end
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!bus.out_valid && n < 300);
                repeat (10) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        chk("accept_after_hold", 64'(acc_cyc), 64'(out_hs_cyc + 1));
        wait_idle();

        // reset in the middle of iterating
        fork
            issue(1'b0, 32'h3333_3333, 1'b1);
            begin
                wait_step(8);
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end
        join
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        issue(1'b1, 32'h4444_4444, 1'b1);
        wait_idle();
        chk("post_rst_lat", 64'(last_lat), 64'd20);

        // both requesters always valid from reset: strict alternation
        do_reset();
        acc_log.delete();
        fork
            for (int k = 0; k < 4; k++) issue(1'b0, $urandom, k == 3);
            for (int k = 0; k < 4; k++) issue(1'b1, $urandom, k == 3);
        join
        wait_idle();
        chk("alt_count", 64'(acc_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < acc_log.size(); k++)
            chk("alt_tag", 64'(acc_log[k]), 64'(k % 2));

        // randomized traffic, enable gaps and back-pressure
        rand_core = 1'b1;
        fork
            begin
                fork
                    for (int k = 0; k < 10; k++) begin
                        repeat ($urandom_range(0, 20)) @(posedge clk);
                        #1 issue(1'b0, $urandom, 1'b1);
                    end
                    for (int k = 0; k < 10; k++) begin
                        repeat ($urandom_range(0, 20)) @(posedge clk);
                        #1 issue(1'b1, $urandom, 1'b1);
                    end
                join
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk); #1;
                clk_en        = ($urandom_range(0, 9) != 0);
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        clk_en = 1'b1;
        bus.out_ready = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
